// File: rtl/trm_pkg.sv
// Shared types and default constants for the test result monitor.
// Holds the FSM state encoding and the default pass/timeout settings.
package trm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } trm_state_e;

  localparam logic [31:0] DEF_PASS_ADDR      = 32'd100;
  localparam logic [31:0] DEF_PASS_DATA      = 32'd25;
  localparam logic [31:0] DEF_TIMEOUT_CYCLES = 32'd100000;

  function automatic logic is_terminal(input trm_state_e s);
    case (s)
      ST_PASS, ST_FAIL, ST_TIMEOUT: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/test_result_monitor_sat_counter.sv
// Saturating up-counter with enable and synchronous clear.
// Holds at all-ones instead of wrapping; clear wins over enable.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         sysclk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_d;
  logic [W-1:0] count_q;

  // next-count selection
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // count register
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/test_result_monitor.sv
// Watches core data stores for the pass/fail mailbox write and bounds the
// run with a qualified-cycle timeout; results are sticky until clear/reset.
module test_result_monitor
  import trm_pkg::*;
#(
  parameter logic [31:0] PASS_ADDR      = DEF_PASS_ADDR,
  parameter logic [31:0] PASS_DATA      = DEF_PASS_DATA,
  parameter logic [31:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             core_clk_en,
  input  logic             mem_write,
  input  logic [31:0]      data_adr,
  input  logic [31:0]      write_data,
  input  logic             clear,
  output logic             success,
  output logic             fail,
  output logic             timeout,
  output logic             done,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_count,
  output logic [15:0]      write_count,
  output logic [31:0]      fail_data
);

  trm_state_e  state_d, state_q;
  logic        success_d, success_q;
  logic        fail_d, fail_q;
  logic        timeout_d, timeout_q;
  logic        done_d, done_q;
  logic [31:0] fail_data_d, fail_data_q;

  logic        qual_store;
  logic        pass_hit;
  logic        pass_val;
  logic        cyc_en;
  logic        wr_en;
  logic        timeout_hit;
  logic [63:0] cyc_ext;
  logic [63:0] cyc_next_ext;

  // A store only counts when the core actually advanced this sysclk cycle.
  assign qual_store = mem_write & core_clk_en;
  assign pass_hit   = qual_store & (data_adr == PASS_ADDR);
  assign pass_val   = (write_data == PASS_DATA);
  assign cyc_en     = core_clk_en & ((state_q == ST_IDLE) | (state_q == ST_RUN));
  assign wr_en      = qual_store & (state_q == ST_RUN);

  // Threshold is judged on the value the counter is about to take.
  assign cyc_ext      = 64'(cycle_count);
  assign cyc_next_ext = (cycle_count == {CNT_W{1'b1}}) ? cyc_ext : (cyc_ext + 64'd1);
  assign timeout_hit  = core_clk_en & (cyc_next_ext >= 64'(TIMEOUT_CYCLES));

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .sysclk (sysclk),
    .reset  (reset),
    .clr    (clear),
    .en     (cyc_en),
    .count  (cycle_count)
  );

  sat_counter #(.W(16)) u_write_cnt (
    .sysclk (sysclk),
    .reset  (reset),
    .clr    (clear),
    .en     (wr_en),
    .count  (write_count)
  );

  // next-state, captured fail value and result flags
  always_comb begin
    state_d     = state_q;
    fail_data_d = fail_data_q;
    if (clear) begin
      state_d     = ST_IDLE;
      fail_data_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (core_clk_en) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (pass_hit) begin
            if (pass_val) begin
              state_d = ST_PASS;
            end else begin
              state_d     = ST_FAIL;
              fail_data_d = write_data;
            end
          end else if (timeout_hit) begin
            state_d = ST_TIMEOUT;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_PASS, ST_FAIL, ST_TIMEOUT: state_d = state_q;
        default:                      state_d = ST_IDLE;
      endcase
    end
    success_d = (state_d == ST_PASS);
    fail_d    = (state_d == ST_FAIL);
    timeout_d = (state_d == ST_TIMEOUT);
    done_d    = is_terminal(state_d);
  end

  // state and result registers
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      success_q   <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
      done_q      <= 1'b0;
      fail_data_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      success_q   <= success_d;
      fail_q      <= fail_d;
      timeout_q   <= timeout_d;
      done_q      <= done_d;
      fail_data_q <= fail_data_d;
    end
  end

  assign state     = state_q;
  assign success   = success_q;
  assign fail      = fail_q;
  assign timeout   = timeout_q;
  assign done      = done_q;
  assign fail_data = fail_data_q;

endmodule

// File: doc/test_result_monitor.md
TEST_RESULT_MONITOR -- requirements
Module: test_result_monitor

Interface
REQ-001 The block SHALL have parameter PASS_ADDR, default 32'd100, meaning the data address whose store decides the test result.
REQ-002 The block SHALL have parameter PASS_DATA, default 32'd25, meaning the store value that signals pass.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 32'd100000, meaning the number of qualified core cycles allowed before timeout.
REQ-004 The block SHALL have parameter CNT_W, default 32, meaning the width of the cycle counter.
REQ-005 The block SHALL have port sysclk, input, 1 bit, meaning the clock.
REQ-006 The block SHALL have port reset, input, 1 bit, meaning the asynchronous, active-high reset.
REQ-007 The block SHALL have port core_clk_en, input, 1 bit, meaning the core received a dbgclk edge this sysclk cycle.
REQ-008 The block SHALL have port mem_write, input, 1 bit, meaning the post-BSR data-memory write strobe.
REQ-009 The block SHALL have port data_adr, input, 32 bits, meaning the post-BSR data address.
REQ-010 The block SHALL have port write_data, input, 32 bits, meaning the post-BSR store data.
REQ-011 The block SHALL have port clear, input, 1 bit, meaning a synchronous return to IDLE.
REQ-012 The block SHALL have port success, fail and timeout, output, 1 bit each, meaning sticky result flags.
REQ-013 The block SHALL have port done, output, 1 bit, meaning the block is in a terminal state.
REQ-014 The block SHALL have port state, output, 3 bits, meaning the encoded FSM state.
REQ-015 The block SHALL have port cycle_count, output, CNT_W bits, meaning qualified cycles counted in RUN.
REQ-016 The block SHALL have port write_count, output, 16 bits, meaning qualified stores counted in RUN.
REQ-017 The block SHALL have port fail_data, output, 32 bits, meaning the store value captured on fail.

Function
REQ-018 A qualified store SHALL be defined as mem_write && core_clk_en in one sysclk cycle; a mem_write held high across ungated sysclk cycles SHALL count once per core_clk_en.
REQ-019 The FSM SHALL have states IDLE, RUN, PASS, FAIL and TIMEOUT.
REQ-020 IDLE SHALL move to RUN on the first cycle with core_clk_en=1, and that cycle SHALL count as cycle 1.
REQ-021 In RUN, a qualified store with data_adr==PASS_ADDR SHALL move the FSM to PASS if write_data==PASS_DATA, and to FAIL otherwise with fail_data<=write_data.
REQ-022 In RUN, when cycle_count reaches TIMEOUT_CYCLES with no deciding store, the FSM SHALL move to TIMEOUT.
REQ-023 If a deciding store and the timeout threshold occur in the same cycle, the deciding store SHALL win.
REQ-024 Flags SHALL be registered; success, fail or timeout SHALL assert the cycle after the deciding edge, and exactly one SHALL be high in a terminal state.
REQ-025 Terminal states SHALL hold until clear or reset, and the counters and fail_data SHALL freeze there.
REQ-026 cycle_count SHALL increment only in RUN on core_clk_en and SHALL saturate at all-ones.
REQ-027 write_count SHALL increment on each qualified store in RUN, including the deciding store, and SHALL saturate at 16'hFFFF.
REQ-028 clear SHALL force IDLE, zero all counters, flags and fail_data on the next edge, and SHALL take priority over any simultaneous store or timeout.
REQ-029 done SHALL equal success|fail|timeout.

Reset
REQ-030 Asserting reset at any time, including mid-RUN, SHALL immediately set state=IDLE, all flags=0, cycle_count=0, write_count=0 and fail_data=0.
REQ-031 Deasserting reset SHALL cause no transition until core_clk_en is seen.

Structure
REQ-032 Package trm_pkg SHALL hold the state enum (IDLE=0, RUN=1, PASS=2, FAIL=3, TIMEOUT=4) and the default PASS_ADDR, PASS_DATA and TIMEOUT_CYCLES constants.
REQ-033 A single sub-module sat_counter, parameterised by width, with enable and synchronous clear, SHALL implement both counters.

Verification
REQ-034 Stores to address 96 then 100 with data 25, core_clk_en=1 -> success=1 the next cycle, write_count=2, state=PASS.
REQ-035 A store to address 100 with data 7 -> fail=1, fail_data=7; a later store to 100 with data 25 -> still FAIL.
REQ-036 TIMEOUT_CYCLES=10 and no stores -> timeout=1 after the 10th core_clk_en, cycle_count=10 and frozen.
REQ-037 mem_write held for 5 sysclk cycles with core_clk_en high for only 1 of them -> write_count=1.
REQ-038 With TIMEOUT_CYCLES=10, a deciding store of 25 on the 10th cycle -> PASS, not TIMEOUT; clear in the same cycle as a store -> IDLE with all counts 0.
REQ-039 Async reset pulsed mid-RUN between sysclk edges -> all outputs 0 and state=IDLE before the next edge.
